// File: rtl/flop_r_pkg.sv
`default_nettype none
// ============================================================================
// Module      : flop_r_pkg
// Description : Shared width limits and word type for the flop_r register.
// Revision    : 1.0 - initial release
// ============================================================================
package flop_r_pkg;

    // Default datapath width (PC register and similar state).
    localparam int unsigned FLOP_R_DEFAULT_W = 64;

    // Widest register the block is expected to be built at.
    localparam int unsigned FLOP_R_MAX_W     = 128;

    // Convenience type for a default-width datapath word.
    typedef logic [FLOP_R_DEFAULT_W-1:0] word_t;

endpackage : flop_r_pkg
`default_nettype wire

// File: rtl/flop_r_bit.sv
`default_nettype none
// ============================================================================
// Module      : flop_r_bit
// Description : Single-bit D flop with asynchronous active-low reset; the
//               value loaded during reset comes from the rst_val_i input so
//               each bit of a wider register can have its own reset value.
// Revision    : 1.0 - initial release
// ============================================================================
module flop_r_bit (
    input  logic clk,
    input  logic reset,
    input  logic rst_val_i,
    input  logic d_i,
    output logic q_o
);

    logic bit_q;

    // Hold the reset value while reset is low, otherwise capture d on each edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_q <= rst_val_i;
        end else begin
            bit_q <= d_i;
        end
    end

    assign q_o = bit_q;

endmodule : flop_r_bit
`default_nettype wire

// File: rtl/flop_r.sv
`default_nettype none
// ============================================================================
// Module      : flop_r
// Description : Parameterized N-bit D register with asynchronous active-low
//               reset. Built from N flop_r_bit cells, bit i resetting to
//               RESET_VAL[i]. No enable: every rising edge out of reset loads d.
//               Define FLOP_R_ASSERT_EN to compile in simulation assertions
//               (reset value held, one-cycle capture, legal width).
// Revision    : 1.0 - initial release
// ============================================================================
module flop_r
    import flop_r_pkg::*;
#(
    parameter int unsigned  N         = FLOP_R_DEFAULT_W,
    parameter logic [N-1:0] RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    // One independent flop per bit; all share the same clock and reset.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_bit
            flop_r_bit u_bit (
                .clk       (clk),
                .reset     (reset),
                .rst_val_i (RESET_VAL[gi]),
                .d_i       (d[gi]),
                .q_o       (q[gi])
            );
        end
    endgenerate

`ifdef FLOP_R_ASSERT_EN
    // Width must stay inside the supported range.
    generate
        if ((N < 1) || (N > FLOP_R_MAX_W)) begin : g_bad_width
            $error("flop_r: N=%0d outside legal range 1..%0d", N, FLOP_R_MAX_W);
        end
    endgenerate

    // While reset is low the output must already sit at the reset value.
    always_comb begin
        if (!reset) begin
            a_reset_async : assert (q == RESET_VAL)
                else $error("flop_r reset: d=%h q=%h expected=%h", d, q, RESET_VAL);
        end
    end

    // Reset value also observed at every clock edge during reset.
    a_reset_clk : assert property (@(posedge clk) !reset |-> (q == RESET_VAL))
        else $error("flop_r reset@clk: d=%h q=%h expected=%h", d, q, RESET_VAL);

    // Out of reset, the output reflects d sampled at the previous edge.
    a_capture : assert property (@(posedge clk) (reset && $past(reset)) |-> (q == $past(d)))
        else $error("flop_r capture: d=%h q=%h expected=%h", d, q, $past(d));
`endif

endmodule : flop_r
`default_nettype wire

// File: tb/tb_flop_r.sv
`default_nettype none
// ============================================================================
// Module      : tb_flop_r
// Description : Self-checking bench for flop_r (N=64 default reset and N=8
//               with RESET_VAL=8'hA5). Expected values come from a small
//               cycle-level model of the register kept in the bench.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flop_r;

    logic        clk;
    logic        reset;
    logic [63:0] d;
    logic [63:0] q;

    logic        reset8;
    logic [7:0]  d8;
    logic [7:0]  q8;

    int unsigned n_checks;
    int unsigned n_pass;

    // Model state: value the register should hold, and what it saw last drive.
    logic [63:0] m_q;
    logic [63:0] d_prev;
    logic        r_prev;

    flop_r #(
        .N         (64),
        .RESET_VAL (64'h0)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .d     (d),
        .q     (q)
    );

    flop_r #(
        .N         (8),
        .RESET_VAL (8'hA5)
    ) u_dut8 (
        .clk   (clk),
        .reset (reset8),
        .d     (d8),
        .q     (q8)
    );

    // 20 ns clock, rising edges at 10, 30, 50 ...
    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One cycle: model the edge, drive new inputs 1 ns later, check on the falling edge.
    task automatic cycle(input string tag, input logic [63:0] dv, input logic rv);
        @(posedge clk);
        if (r_prev) m_q = d_prev;
        #1;
        d     = dv;
        reset = rv;
        if (!rv) m_q = '0;
        d_prev = dv;
        r_prev = rv;
        @(negedge clk);
        chk(tag, q, m_q);
    endtask

    // Short reset pulse entirely between two edges.
    task automatic mid_pulse(input string tag);
        #3 reset = 1'b0;
        m_q = '0;
        #1 chk(tag, q, m_q);
        #1 reset = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        reset8   = 1'b1;
        d        = '0;
        d8       = '0;
        m_q      = '0;
        d_prev   = '0;
        r_prev   = 1'b0;
        #2 reset = 1'b0;

        // Reset held for five cycles with varying d.
        for (int i = 0; i < 5; i++) begin
            cycle("reset_hold", 64'hFFFF_FFFF_FFFF_FFFF - 64'(i), 1'b0);
        end

        // Release and stream data.
        for (int i = 0; i < 5; i++) begin
            cycle("stream", 64'hFFFF_FFFF_FFFF_FFFA - 64'(i), 1'b1);
        end
        cycle("stream_last", 64'h1234, 1'b1);
        cycle("load_1234", 64'h1234, 1'b1);
        chk("q_is_1234", q, 64'h1234);

        // Mid-cycle reset assertion clears q immediately.
        #3 reset = 1'b0;
        #1 chk("mid_reset", q, 64'h0);
        m_q    = '0;
        d      = 64'h55;
        d_prev = 64'h55;

        // Release coinciding with a rising edge: that edge must not capture.
        // The nonblocking update lets the DUT see reset still low at this edge.
        @(posedge clk);
        reset <= 1'b1;
        r_prev = 1'b1;
        @(negedge clk);
        chk("release_on_edge", q, 64'h0);
        cycle("after_release", 64'h55, 1'b1);
        chk("q_is_55", q, 64'h55);

        // Toggle d within one cycle; only the final value is captured.
        @(posedge clk);
        m_q = d_prev;
        #1 d = 64'hA;
        #2 d = 64'hB;
        #2 d = 64'hA;
        chk("glitch_mid", q, 64'h55);
        #2 d = 64'hB;
        d_prev = 64'hB;
        @(negedge clk);
        chk("glitch_hold", q, 64'h55);
        cycle("glitch_load", 64'hB, 1'b1);
        chk("q_is_B", q, 64'hB);

        // Narrow instance with a non-zero reset value.
        reset8 = 1'b0;
        #1 chk("r8_async", {56'h0, q8}, 64'hA5);
        @(negedge clk);
        chk("r8_hold", {56'h0, q8}, 64'hA5);
        #3;
        d8     = 8'h3C;
        reset8 = 1'b1;
        @(negedge clk);
        chk("r8_load", {56'h0, q8}, 64'h3C);

        // Randomized traffic with occasional reset cycles and mid-cycle pulses.
        for (int i = 0; i < 60; i++) begin
            cycle("rand", {$urandom, $urandom}, ($urandom_range(7) != 0));
            if (r_prev && ($urandom_range(9) == 0)) begin
                mid_pulse("rand_pulse");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_flop_r
`default_nettype wire
